// File: rtl/uart_tx_queue_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_queue_pkg
// Shared definitions for the UART transmit queue:
//   - FSM state encoding used by uart_tx_queue
//   - ptr_width(): pointer width derived from the queue depth, used by
//     sync_fifo and by the top-level count port
// -----------------------------------------------------------------------------
package uart_tx_queue_pkg;

    // Transmit FSM states
    localparam logic [1:0] ST_IDLE   = 2'd0;  // nothing in flight, txStart low
    localparam logic [1:0] ST_LOAD   = 2'd1;  // latching head entry onto txIn
    localparam logic [1:0] ST_ACTIVE = 2'd2;  // frame in flight, txStart high

    // Pointer width for a power-of-two depth; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Circular-buffer byte store with registered occupancy flags.
//   clk, reset  : system clock, synchronous active-high reset
//   flush_i     : zero both pointers and the count
//   push_i      : write wr_data_i (ignored while full, flushing or in reset)
//   pop_i       : drop the head entry (ignored while empty, flushing or in reset)
//   wr_data_i   : entry to write
//   rd_data_o   : registered copy of the head entry, valid one edge after the
//                 head entry was written or the head pointer moved
//   count_o     : occupancy, full_o / empty_o : registered occupancy flags
// -----------------------------------------------------------------------------
module sync_fifo
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush_i,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [DATA_WIDTH-1:0]     wr_data_i,
    output logic [DATA_WIDTH-1:0]     rd_data_o,
    output logic [ptr_width(DEPTH):0] count_o,
    output logic                      full_o,
    output logic                      empty_o
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_q, empty_q;
    logic                  push_ok, pop_ok;

    assign push_ok = push_i & ~full_q  & ~flush_i & ~reset;
    assign pop_ok  = pop_i  & ~empty_q & ~flush_i & ~reset;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        if (reset || flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CNT_FULL);
            empty_q  <= (count_d == '0);
        end
    end

    // Storage with registered read addressed by the next head pointer, so the
    // new head is available one edge after a pop. When the slot being written
    // is the next head (queue empty or draining to one entry), the write data
    // is forwarded because the array read returns the old contents.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
        if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
            rd_data_q <= wr_data_i;
        end else begin
            rd_data_q <= mem[rd_ptr_d];
        end
    end

    assign rd_data_o = rd_data_q;
    assign count_o   = count_q;
    assign full_o    = full_q;
    assign empty_o   = empty_q;

endmodule

// File: rtl/uart_tx_queue.sv
// -----------------------------------------------------------------------------
// uart_tx_queue
// Byte queue in front of a Uart8 transmitter. Bytes pushed on wrEn are sent
// in order; consecutive bytes go out back-to-back with txStart held high.
//   clk, reset   : system clock, synchronous active-high reset
//   wrEn, wrData : push one byte per asserted cycle
//   flush        : discard everything queued and return to idle
//   full, empty, count : registered occupancy
//   overflow     : one-cycle pulse when a push hits a full queue
//   overflowErr  : sticky overflow flag, cleared only by reset
//   txStart, txIn: to Uart8; txBusy, txDone: from Uart8
// -----------------------------------------------------------------------------
module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wrEn,
    input  logic [DATA_WIDTH-1:0]     wrData,
    input  logic                      flush,
    output logic                      full,
    output logic                      empty,
    output logic [ptr_width(DEPTH):0] count,
    output logic                      overflow,
    output logic                      overflowErr,
    output logic                      txStart,
    output logic [DATA_WIDTH-1:0]     txIn,
    input  logic                      txBusy,
    input  logic                      txDone
);

    logic [1:0]            state_q, state_d;
    logic                  txstart_q, txstart_d;
    logic [DATA_WIDTH-1:0] txin_q, txin_d;
    logic                  popped_q, popped_d;   // head was popped on the last edge
    logic                  txdone_prev_q;
    logic                  overflow_q, overflow_err_q;

    logic [DATA_WIDTH-1:0] head;
    logic                  fifo_full, fifo_empty;
    logic                  txdone_rise, pop_go, drop;

    assign txdone_rise = txDone & ~txdone_prev_q;
    // Only a frame this FSM started (ACTIVE, head not yet popped) may pop.
    assign pop_go = (state_q == ST_ACTIVE) & ~popped_q & txdone_rise & ~fifo_empty & ~flush;
    // Flush discards a coincident push silently.
    assign drop   = wrEn & fifo_full & ~flush;

    sync_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush_i   (flush),
        .push_i    (wrEn),
        .pop_i     (pop_go),
        .wr_data_i (wrData),
        .rd_data_o (head),
        .count_o   (count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        txstart_d = txstart_q;
        txin_d    = txin_q;
        popped_d  = pop_go;
        case (state_q)
            ST_IDLE: begin
                txstart_d = 1'b0;
                if (!fifo_empty && !txBusy) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                txin_d    = head;
                txstart_d = 1'b1;
                state_d   = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                // One edge after a pop: chain the next byte or fall idle.
                if (popped_q) begin
                    if (!fifo_empty) begin
                        txin_d = head;
                    end else begin
                        txstart_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: begin
                txstart_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
        if (flush) begin
            state_d   = ST_IDLE;
            txstart_d = 1'b0;
            popped_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            txstart_q      <= 1'b0;
            txin_q         <= '0;
            popped_q       <= 1'b0;
            txdone_prev_q  <= 1'b0;
            overflow_q     <= 1'b0;
            overflow_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            txstart_q      <= txstart_d;
            txin_q         <= txin_d;
            popped_q       <= popped_d;
            txdone_prev_q  <= txDone;
            overflow_q     <= drop;
            overflow_err_q <= overflow_err_q | drop;
        end
    end

    assign full        = fifo_full;
    assign empty       = fifo_empty;
    assign overflow    = overflow_q;
    assign overflowErr = overflow_err_q;
    assign txStart     = txstart_q;
    assign txIn        = txin_q;

endmodule
